sram_arbiter: RTL

Four-port request arbiter directly upstream of the 32-bit-word SRAM controller. It serializes word read/write requests from display scanout (port 0), rasterizer framebuffer writes (port 1), texture fetch (port 2) and SPI host access (port 3) onto the controller's single req/ack interface. Port 0 has strict priority. Ports 1-3 share round-robin. Completion (ack plus read data) is routed back to the granted port.

---
 rtl/sram_arbiter_if.sv | 32 +++
 rtl/sram_arbiter.sv | 77 +++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle of the four requester ports and the SRAM controller req/ack link.
// The arbiter takes the slave view; the requesters/controller side takes the master view.
`timescale 1ns/1ps
interface sram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [3:0]          port_req;
    logic [3:0]          port_we;
    logic [4*ADDR_W-1:0] port_addr;
    logic [4*DATA_W-1:0] port_wdata;
    logic [3:0]          port_grant;
    logic [3:0]          port_ack;
    logic [DATA_W-1:0]   port_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;
    logic                mem_ready;

    modport slave (
        input  port_req, port_we, port_addr, port_wdata, mem_rdata, mem_ack, mem_ready,
        output port_grant, port_ack, port_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output port_req, port_we, port_addr, port_wdata, mem_rdata, mem_ack, mem_ready,
        input  port_grant, port_ack, port_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Four-port SRAM request arbiter: port 0 strict priority, ports 1-3 round-robin,
// one access outstanding, completion routed back to the owning port one cycle after mem_ack.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

    state_t              r_state;
    logic [1:0]          r_owner;
    logic [1:0]          r_rr_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_issue;
    logic [1:0]          w_winner;
    logic [1:0]          w_c1;
    logic [1:0]          w_c2;

    function automatic logic [1:0] next_rr(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    assign w_c1 = next_rr(r_rr_ptr);
    assign w_c2 = next_rr(w_c1);

    always_comb begin
        w_winner = 2'd0;
        if (bus.port_req[0])              w_winner = 2'd0;
        else if (bus.port_req[r_rr_ptr])  w_winner = r_rr_ptr;
        else if (bus.port_req[w_c1])      w_winner = w_c1;
        else if (bus.port_req[w_c2])      w_winner = w_c2;
    end

    // Issue is decided in the same cycle the request is seen so a grant can share the ACK cycle;
    // rst_n gating keeps every output quiet while reset is held.
    assign w_issue = rst_n && (r_state != S_BUSY) && bus.mem_ready && (bus.port_req != 4'd0);

    assign bus.port_grant = w_issue ? (4'b0001 << w_winner) : 4'b0000;
    assign bus.mem_req    = w_issue;
    assign bus.mem_we     = w_issue ? bus.port_we[w_winner] : r_we;
    assign bus.mem_addr   = w_issue ? bus.port_addr[int'(w_winner)*ADDR_W +: ADDR_W] : r_addr;
    assign bus.mem_wdata  = w_issue ? bus.port_wdata[int'(w_winner)*DATA_W +: DATA_W] : r_wdata;
    assign bus.port_ack   = (r_state == S_ACK) ? (4'b0001 << r_owner) : 4'b0000;
    assign bus.port_rdata = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= 2'd0;
            r_rr_ptr <= 2'd1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_BUSY:  if (bus.mem_ack) r_state <= S_ACK;
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_issue) begin
                r_state <= S_BUSY;
                r_owner <= w_winner;
                r_we    <= bus.port_we[w_winner];
                r_addr  <= bus.port_addr[int'(w_winner)*ADDR_W +: ADDR_W];
                r_wdata <= bus.port_wdata[int'(w_winner)*DATA_W +: DATA_W];
                if (w_winner != 2'd0) r_rr_ptr <= next_rr(w_winner);
            end
        end
    end
endmodule
